ram_rx_arbiter: RTL and testbench

//  Shares the single data-RAM port between the CPU load/store path and a UART

---
 rtl/ram_rx_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_rx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_rx_arbiter: shares the data-RAM port between CPU and a UART RX ring   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_rx_arbiter #(
  parameter logic [31:0] BUF_BASE   = 32'h1200,
  parameter int          BUF_WORDS  = 64,
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] CTRL_ADDR  = 32'h11FC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [31:0]                  cpu_addr,
  input  logic [31:0]                  cpu_wdata,
  output logic                         cpu_gnt,
  output logic [31:0]                  cpu_rdata,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_byte,
  output logic                         rx_ready,
  output logic                         ram_we,
  output logic [31:0]                  ram_addr,
  output logic [31:0]                  ram_wdata,
  input  logic [31:0]                  ram_rdata,
  output logic [$clog2(BUF_WORDS)-1:0] wr_ptr,
  output logic                         wrapped
);

  localparam int                   c_ptr_w      = $clog2(BUF_WORDS);
  localparam int                   c_starve_w   = $clog2(STARVE_MAX + 1);
  localparam logic [c_ptr_w-1:0]   c_ptr_last   = c_ptr_w'(BUF_WORDS - 1);
  localparam logic [c_ptr_w-1:0]   c_ptr_one    = c_ptr_w'(1);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);
  localparam logic [c_starve_w-1:0] c_starve_one = c_starve_w'(1);

  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_shift;
  logic [31:0]           r_pend_word;
  logic                  r_pending;
  logic [c_starve_w-1:0] r_starve;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic                  r_wrapped;

  logic       w_starved;
  logic       w_cpu_own;
  logic       w_rx_grant;
  logic       w_ctrl_hit;
  logic       w_ctrl_clr;
  logic       w_accept;
  logic       w_last_byte;
  logic [7:0] w_ptr8;

  // Starvation only bites when an RX word is actually waiting.
  assign w_starved   = r_pending && (r_starve == c_starve_max);
  assign w_cpu_own   = rst && cpu_req && !w_starved;
  assign w_rx_grant  = rst && !w_cpu_own && r_pending;
  assign w_ctrl_hit  = (cpu_addr == CTRL_ADDR);
  assign w_ctrl_clr  = w_cpu_own && cpu_we && w_ctrl_hit;
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_ptr8      = 8'(r_wr_ptr);

  // The completing byte may only enter when the pending slot is free or draining now.
  assign rx_ready = rst && !(r_pending && w_last_byte && !w_rx_grant);
  assign w_accept = rx_valid && rx_ready;

  assign wr_ptr  = r_wr_ptr;
  assign wrapped = r_wrapped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt  <= 2'd0;
      r_shift     <= 24'd0;
      r_pend_word <= 32'd0;
    end else if (w_accept) begin
      if (w_last_byte) begin
        r_pend_word <= {rx_byte, r_shift};
        r_byte_cnt  <= 2'd0;
      end else begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_shift[7:0]   <= rx_byte;
          2'd1:    r_shift[15:8]  <= rx_byte;
          default: r_shift[23:16] <= rx_byte;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
      r_starve  <= '0;
    end else begin
      if (w_accept && w_last_byte) begin
        r_pending <= 1'b1;
      end else if (w_rx_grant) begin
        r_pending <= 1'b0;
      end

      if (w_rx_grant || !r_pending) begin
        r_starve <= '0;
      end else if (w_cpu_own) begin
        r_starve <= r_starve + c_starve_one;
      end
    end
  end

  // CTRL clear and RX write are exclusive because only one owner exists per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_wrapped <= 1'b0;
    end else if (w_ctrl_clr) begin
      r_wr_ptr  <= '0;
      r_wrapped <= 1'b0;
    end else if (w_rx_grant) begin
      if (r_wr_ptr == c_ptr_last) begin
        r_wr_ptr  <= '0;
        r_wrapped <= 1'b1;
      end else begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
    end
  end

  always_comb begin
    cpu_gnt   = 1'b0;
    cpu_rdata = 32'd0;
    ram_we    = 1'b0;
    ram_addr  = 32'd0;
    ram_wdata = 32'd0;
    if (w_cpu_own) begin
      cpu_gnt   = 1'b1;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we && !w_ctrl_hit;
      cpu_rdata = w_ctrl_hit ? {r_wrapped, 23'd0, w_ptr8} : ram_rdata;
    end else if (w_rx_grant) begin
      ram_we    = 1'b1;
      ram_addr  = BUF_BASE + 32'({r_wr_ptr, 2'b00});
      ram_wdata = r_pend_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_rx_arbiter.sv
`default_nettype none
// Scoreboard bench for ram_rx_arbiter: expected RAM/CPU events are queued by the
// stimulus and popped by a negedge monitor whenever the DUT grants the port.
module tb_ram_rx_arbiter;

  localparam logic [31:0] CTRL = 32'h11FC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt;
  logic [31:0] cpu_rdata;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [5:0]  wr_ptr;
  logic        wrapped;

  ram_rx_arbiter #(
    .BUF_BASE(32'h1200), .BUF_WORDS(64), .STARVE_MAX(4), .CTRL_ADDR(CTRL)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_ptr(wr_ptr), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  // RAM read data is a fixed function of the address so pass-through is observable.
  assign ram_rdata = ram_addr ^ 32'hFFFF_0000;

  typedef struct packed {
    logic        gnt;
    logic        we;
    logic        chkrd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  tests  = 0;
  int  fails  = 0;
  int  stalls = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void push_ev(input logic g, input logic w, input logic c,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] r);
    ev_t e;
    e.gnt = g; e.we = w; e.chkrd = c; e.addr = a; e.wdata = d; e.rdata = r;
    exp_q.push_back(e);
  endfunction

  function automatic void push_cpu(input logic we, input logic [31:0] a, input logic [31:0] d);
    push_ev(1'b1, we, 1'b1, a, d, a ^ 32'hFFFF_0000);
  endfunction

  function automatic void push_rx(input logic [31:0] a, input logic [31:0] d);
    push_ev(1'b0, 1'b1, 1'b0, a, d, 32'd0);
  endfunction

  function automatic void push_ctrl_ld(input logic [31:0] status);
    push_ev(1'b1, 1'b0, 1'b1, CTRL, 32'd0, status);
  endfunction

  function automatic void push_ctrl_st(input logic [31:0] d);
    push_ev(1'b1, 1'b0, 1'b0, CTRL, d, 32'd0);
  endfunction

  always @(negedge clk) begin
    if (rst && (cpu_gnt || ram_we)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got gnt=%b we=%b addr=%h wdata=%h expected none",
                 cpu_gnt, ram_we, ram_addr, ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_gnt", 32'(cpu_gnt), 32'(mon_e.gnt));
        chk("ev_we", 32'(ram_we), 32'(mon_e.we));
        chk("ev_addr", ram_addr, mon_e.addr);
        chk("ev_wdata", ram_wdata, mon_e.wdata);
        if (mon_e.chkrd) chk("ev_rdata", cpu_rdata, mon_e.rdata);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_acc(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cpu_gnt) break;
      @(posedge clk);
      #1;
    end
    if (n == 50) begin
      tests++;
      fails++;
      $display("FAIL cpu_timeout: got no grant for addr %h expected grant", a);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    int n;
    rx_valid = 1'b1; rx_byte = b;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rx_ready) break;
      stalls++;
      @(posedge clk);
      #1;
    end
    if (n == 50) begin
      tests++;
      fails++;
      $display("FAIL rx_timeout: got no accept for byte %h expected accept", b);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_word(input logic [31:0] w);
    rx_send(w[7:0]); rx_send(w[15:8]); rx_send(w[23:16]); rx_send(w[31:24]);
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d events outstanding expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] kb;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1000; cpu_wdata = 32'h1234_5678;
    rx_valid = 1'b1; rx_byte = 8'h55;

    // Reset: outputs forced low even with live requests.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; rx_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    sync();

    // T1: simple packing into ring word 0.
    push_rx(32'h1200, 32'h4433_2211);
    rx_word(32'h4433_2211);
    wait_drain("t1");
    chk("t1_wr_ptr", 32'(wr_ptr), 32'd1);

    // T2: starvation bound, CPU stream overlapping an RX word.
    sync();
    for (int i = 0; i < 8; i++) push_cpu(1'b1, 32'h1000 + 32'(4 * i), 32'(i));
    push_rx(32'h1204, 32'hA3A2_A1A0);
    push_cpu(1'b1, 32'h1020, 32'd8);
    fork
      begin
        for (int i = 0; i < 9; i++) cpu_acc(1'b1, 32'h1000 + 32'(4 * i), 32'(i));
        cpu_req = 1'b0;
      end
      rx_word(32'hA3A2_A1A0);
    join
    wait_drain("t2");
    chk("t2_wr_ptr", 32'(wr_ptr), 32'd2);

    // T4: plain load, status read, status clear.
    sync();
    push_cpu(1'b0, 32'h1100, 32'd0);
    push_ctrl_ld(32'h0000_0002);
    push_ctrl_st(32'hDEAD_BEEF);
    push_ctrl_ld(32'h0000_0000);
    cpu_acc(1'b0, 32'h1100, 32'd0);
    cpu_acc(1'b0, CTRL, 32'd0);
    cpu_acc(1'b1, CTRL, 32'hDEAD_BEEF);
    cpu_acc(1'b0, CTRL, 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    wait_drain("t4");
    chk("t4_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("t4_wrapped", 32'(wrapped), 32'd0);

    // T3: BUF_WORDS+1 words, ring wrap.
    sync();
    for (int k = 0; k < 65; k++) begin
      kb = 8'(k);
      push_rx(32'h1200 + 32'(4 * (k % 64)), {8'hC3, 8'h0F, kb ^ 8'h55, kb});
      rx_word({8'hC3, 8'h0F, kb ^ 8'h55, kb});
      if (k == 62) begin
        wait_drain("t3a");
        chk("t3_ptr_63", 32'(wr_ptr), 32'd63);
        chk("t3_nowrap", 32'(wrapped), 32'd0);
        sync();
      end
      if (k == 63) begin
        wait_drain("t3b");
        chk("t3_ptr_0", 32'(wr_ptr), 32'd0);
        chk("t3_wrap", 32'(wrapped), 32'd1);
        sync();
      end
    end
    wait_drain("t3c");
    chk("t3_ptr_1", 32'(wr_ptr), 32'd1);
    chk("t3_wrap_sticky", 32'(wrapped), 32'd1);
    sync();
    push_ctrl_ld(32'h8000_0001);
    cpu_acc(1'b0, CTRL, 32'd0);
    cpu_req = 1'b0;
    wait_drain("t3d");

    // T5: 4th byte held off while pending, accepted on the RX-grant cycle.
    sync();
    stalls = 0;
    for (int i = 0; i < 8; i++) push_cpu(1'b1, 32'h1040 + 32'(4 * i), 32'h100 + 32'(i));
    push_rx(32'h1204, 32'h0403_0201);
    for (int i = 8; i < 12; i++) push_cpu(1'b1, 32'h1040 + 32'(4 * i), 32'h100 + 32'(i));
    push_rx(32'h1208, 32'h0807_0605);
    push_cpu(1'b1, 32'h1040 + 32'(4 * 12), 32'h100 + 32'd12);
    fork
      begin
        for (int i = 0; i < 13; i++) cpu_acc(1'b1, 32'h1040 + 32'(4 * i), 32'h100 + 32'(i));
        cpu_req = 1'b0;
      end
      begin
        for (int b = 1; b <= 8; b++) rx_send(8'(b));
        rx_valid = 1'b0;
      end
    join
    wait_drain("t5");
    chk("t5_stalls", 32'(stalls), 32'd1);
    chk("t5_wr_ptr", 32'(wr_ptr), 32'd3);

    // T6: async reset with a pending word and a partial word.
    sync();
    for (int i = 0; i < 7; i++) push_cpu(1'b1, 32'h1080 + 32'(4 * i), 32'h200 + 32'(i));
    fork
      for (int i = 0; i < 7; i++) cpu_acc(1'b1, 32'h1080 + 32'(4 * i), 32'h200 + 32'(i));
      begin
        for (int b = 0; b < 6; b++) rx_send(8'h71 + 8'(b));
        rx_valid = 1'b0;
      end
    join
    rst = 1'b0;
    #1;
    chk("t6_gnt", 32'(cpu_gnt), 32'd0);
    chk("t6_we", 32'(ram_we), 32'd0);
    chk("t6_addr", ram_addr, 32'd0);
    chk("t6_wdata", ram_wdata, 32'd0);
    chk("t6_rdata", cpu_rdata, 32'd0);
    chk("t6_rx_ready", 32'(rx_ready), 32'd0);
    chk("t6_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("t6_wrapped", 32'(wrapped), 32'd0);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    sync();
    push_rx(32'h1200, 32'hEFBE_ADDE);
    rx_word(32'hEFBE_ADDE);
    wait_drain("t6");
    chk("t6_wr_ptr_after", 32'(wr_ptr), 32'd1);

    repeat (3) @(posedge clk);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
